// File: rtl/sdcard_spi_responder.sv
// sdcard_spi_responder: SPI-mode SD card model answering CMD0/CMD1/CMD17 with block reads from a byte memory port
module sdcard_spi_responder #(
  parameter int NCR        = 8,
  parameter int NAC        = 16,
  parameter int INIT_POLLS = 3,
  parameter int GEN_CRC16  = 1
) (
  input  logic        clk_i,
  input  logic        rst_x_i,
  input  logic        cs_i,
  input  logic        di_i,
  output logic        do_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_adr_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        card_ready_o,
  output logic [5:0]  last_cmd_o
);
  typedef enum logic [2:0] {RX, NCR_WAIT, SEND_R1, NAC_WAIT, SEND_TOKEN, SEND_DATA, SEND_CRC} state_t;
  typedef enum logic [1:0] {UNINIT, IDLE, READY} card_t;
  localparam logic [7:0] NCR_END  = 8'(NCR - 1);
  localparam logic [7:0] NAC_END  = 8'(NAC - 1);
  localparam logic [3:0] POLL_END = 4'(INIT_POLLS);
  state_t      state_q, state_d;
  card_t       card_q, card_d, card_p_q, card_p_d, card_n;
  logic [3:0]  polls_q, polls_d, polls_p_q, polls_p_d, polls_n, poll_inc;
  logic        rx_act_q, rx_act_d, data_q, data_d, data_n, resp, ready, crc_ok;
  logic [46:0] sr_q, sr_d;
  logic [7:0]  cnt_q, cnt_d, tx_q, tx_d, nxt_q, nxt_d, r1;
  logic [8:0]  byte_q, byte_d;
  logic [15:0] crc_q, crc_d, crc_step;
  logic [31:0] adr_q, adr_d, arg_q, arg_d;
  logic [5:0]  last_q, last_d, idx;
  logic [47:0] frame;
  logic        valid;
  assign frame        = {sr_q, di_i};
  assign idx          = frame[45:40];
  assign valid        = !frame[47] && frame[46] && frame[0];
  assign crc_ok       = frame[7:1] == 7'h4A;
  assign ready        = card_q == READY;
  assign poll_inc     = polls_q + 4'd1;
  assign crc_step     = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ tx_q[7]) ? 16'h1021 : 16'h0000);
  assign card_ready_o = ready;
  assign mem_adr_o    = adr_q;
  assign last_cmd_o   = last_q;
  // R1 and pending card state for the frame completing this cycle
  always_comb begin
    resp    = 1'b1;
    r1      = 8'h00;
    card_n  = card_q;
    polls_n = polls_q;
    data_n  = 1'b0;
    if (idx == 6'd0) begin
      r1      = crc_ok ? 8'h01 : 8'h09;
      card_n  = crc_ok ? IDLE : card_q;
      polls_n = crc_ok ? 4'd0 : polls_q;
    end else if (card_q == UNINIT) begin
      resp = 1'b0;
    end else if (idx == 6'd1) begin
      polls_n = ready ? polls_q : poll_inc;
      card_n  = (ready || poll_inc == POLL_END) ? READY : IDLE;
      r1      = (ready || poll_inc == POLL_END) ? 8'h00 : 8'h01;
    end else if (idx == 6'd17) begin
      r1     = !ready ? 8'h05 : (frame[16:8] != 9'd0 ? 8'h20 : 8'h00);
      data_n = ready && frame[16:8] == 9'd0;
    end else begin
      r1 = {5'd0, 1'b1, 1'b0, !ready};
    end
  end
  // next-state, bit shifters, prefetch and DO/MEM_RD generation
  always_comb begin
    state_d   = state_q;
    card_d    = card_q;
    polls_d   = polls_q;
    card_p_d  = card_p_q;
    polls_p_d = polls_p_q;
    rx_act_d  = rx_act_q;
    data_d    = data_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q + 8'd1;
    tx_d      = {tx_q[6:0], 1'b1};
    nxt_d     = nxt_q;
    byte_d    = byte_q;
    crc_d     = crc_q;
    adr_d     = adr_q;
    arg_d     = arg_q;
    last_d    = last_q;
    do_o      = 1'b1;
    mem_rd_o  = 1'b0;
    case (state_q)
      RX: begin
        tx_d  = tx_q;
        cnt_d = cnt_q;
        if (rx_act_q) begin
          sr_d  = {sr_q[45:0], di_i};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd47) begin
            rx_act_d = 1'b0;
            cnt_d    = 8'd0;
            if (valid) begin
              last_d = idx;
              if (resp) begin
                state_d   = NCR_WAIT;
                tx_d      = r1;
                card_p_d  = card_n;
                polls_p_d = polls_n;
                data_d    = data_n;
                arg_d     = frame[39:8];
              end
            end
          end
        end else if (!di_i) begin
          rx_act_d = 1'b1;
          sr_d     = 47'd0;
          cnt_d    = 8'd1;
        end
      end
      NCR_WAIT: begin
        tx_d = tx_q;
        if (cnt_q == NCR_END) begin
          state_d = SEND_R1;
          cnt_d   = 8'd0;
        end
      end
      SEND_R1: begin
        do_o = tx_q[7];
        if (cnt_q == 8'd7) begin
          state_d = data_q ? NAC_WAIT : RX;
          card_d  = card_p_q;
          polls_d = polls_p_q;
          cnt_d   = 8'd0;
        end
      end
      NAC_WAIT: begin
        if (cnt_q == NAC_END) begin
          state_d = SEND_TOKEN;
          cnt_d   = 8'd0;
          tx_d    = 8'hFE;
          adr_d   = arg_q;
          byte_d  = 9'd0;
          crc_d   = GEN_CRC16 != 0 ? 16'h0000 : 16'hFFFF;
        end
      end
      SEND_TOKEN: begin
        do_o     = tx_q[7];
        mem_rd_o = cnt_q == 8'd2;
        nxt_d    = cnt_q == 8'd3 ? mem_rdata_i : nxt_q;
        if (cnt_q == 8'd7) begin
          state_d = SEND_DATA;
          tx_d    = nxt_q;
          cnt_d   = 8'd0;
        end
      end
      SEND_DATA: begin
        do_o     = tx_q[7];
        crc_d    = GEN_CRC16 != 0 ? crc_step : crc_q;
        mem_rd_o = cnt_q == 8'd2 && byte_q != 9'd511;
        adr_d    = (cnt_q == 8'd1 && byte_q != 9'd511) ? adr_q + 32'd1 : adr_q;
        nxt_d    = cnt_q == 8'd3 ? mem_rdata_i : nxt_q;
        if (cnt_q == 8'd7) begin
          cnt_d   = 8'd0;
          state_d = byte_q == 9'd511 ? SEND_CRC : SEND_DATA;
          byte_d  = byte_q + 9'd1;
          tx_d    = nxt_q;
        end
      end
      SEND_CRC: begin
        do_o  = crc_q[15];
        crc_d = {crc_q[14:0], 1'b0};
        if (cnt_q == 8'd15) begin
          state_d = RX;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = RX;
    endcase
    if (cs_i) begin
      state_d  = RX;
      rx_act_d = 1'b0;
      cnt_d    = 8'd0;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_x_i) begin
      state_q   <= RX;
      card_q    <= UNINIT;
      polls_q   <= 4'd0;
      card_p_q  <= UNINIT;
      polls_p_q <= 4'd0;
      rx_act_q  <= 1'b0;
      data_q    <= 1'b0;
      sr_q      <= 47'd0;
      cnt_q     <= 8'd0;
      tx_q      <= 8'hFF;
      nxt_q     <= 8'd0;
      byte_q    <= 9'd0;
      crc_q     <= 16'd0;
      adr_q     <= 32'd0;
      arg_q     <= 32'd0;
      last_q    <= 6'd0;
    end else begin
      state_q   <= state_d;
      card_q    <= card_d;
      polls_q   <= polls_d;
      card_p_q  <= card_p_d;
      polls_p_q <= polls_p_d;
      rx_act_q  <= rx_act_d;
      data_q    <= data_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      nxt_q     <= nxt_d;
      byte_q    <= byte_d;
      crc_q     <= crc_d;
      adr_q     <= adr_d;
      arg_q     <= arg_d;
      last_q    <= last_d;
    end
  end
endmodule

// File: tb/tb_sdcard_spi_responder.sv
// tb_sdcard_spi_responder: directed checks of the SD SPI card model
module tb_sdcard_spi_responder;
  logic        clk = 1'b0, rst_x = 1'b0, cs = 1'b1, di = 1'b1;
  logic        do_w, mem_rd, card_ready;
  logic [31:0] mem_adr;
  logic [7:0]  mem_rdata = 8'd0;
  logic [5:0]  last_cmd;
  int          errs = 0, checks = 0, rd_cnt = 0, rd_mark = 0;
  logic        rd_chk = 1'b0;
  logic [31:0] rd_base = 32'd0;
  logic [31:0] v;
  int          z, base_cnt;
  sdcard_spi_responder dut (
    .clk_i(clk), .rst_x_i(rst_x), .cs_i(cs), .di_i(di), .do_o(do_w),
    .mem_rd_o(mem_rd), .mem_adr_o(mem_adr), .mem_rdata_i(mem_rdata),
    .card_ready_o(card_ready), .last_cmd_o(last_cmd)
  );
  always #5 clk = ~clk;
  // memory returns the low address byte one cycle after the strobe
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_adr[7:0];
  // every read address inside a checked block must follow the sweep
  always @(negedge clk) begin
    if (mem_rd) begin
      if (rd_chk) chk("mem_adr", mem_adr, rd_base + 32'(rd_cnt - rd_mark));
      rd_cnt++;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [47:0] frm(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    return {2'b01, idx, arg, crc};
  endfunction
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction
  task automatic send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      di = f[i];
    end
  endtask
  task automatic rd(input int n, output logic [31:0] val);
    val = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      di  = 1'b1;
      val = {val[30:0], do_w};
    end
  endtask
  task automatic zeros(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      di = 1'b1;
      if (!do_w) cnt++;
    end
  endtask
  task automatic cmd_r1(input string tag, input logic [47:0] f, input logic [7:0] exp);
    logic [31:0] r;
    send(f);
    rd(8, r);
    chk({tag, "_ncr"}, r, 32'hFF);
    rd(8, r);
    chk(tag, r, {24'd0, exp});
  endtask
  task automatic full_block(input logic [31:0] base);
    logic [31:0] r;
    logic [15:0] c = 16'd0;
    rd(16, r);
    chk("nac", r, 32'hFFFF);
    rd(8, r);
    chk("token", r, 32'hFE);
    for (int k = 0; k < 512; k++) begin
      rd(8, r);
      chk("data", r, (base + 32'(k)) & 32'hFF);
      c = crc_byte(c, 8'(base + 32'(k)));
    end
    rd(16, r);
    chk("crc", r, {16'd0, c});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_do", do_w, 1);
    chk("rst_rd", mem_rd, 0);
    chk("rst_adr", mem_adr, 0);
    chk("rst_ready", card_ready, 0);
    chk("rst_last", last_cmd, 0);
    rst_x = 1'b1;
    cs    = 1'b0;
    send(frm(6'd17, 32'd0, 8'h01));
    zeros(200, z);
    chk("uninit_do", z, 0);
    chk("uninit_rd", rd_cnt, 0);
    chk("uninit_ready", card_ready, 0);
    chk("uninit_last", last_cmd, 17);
    cmd_r1("cmd0", frm(6'd0, 32'd0, 8'h95), 8'h01);
    chk("cmd0_last", last_cmd, 0);
    cmd_r1("cmd0_badcrc", frm(6'd0, 32'd0, 8'h01), 8'h09);
    cmd_r1("cmd0b", frm(6'd0, 32'd0, 8'h95), 8'h01);
    cmd_r1("cmd1_a", frm(6'd1, 32'd0, 8'h01), 8'h01);
    chk("ready_poll1", card_ready, 0);
    cmd_r1("cmd1_b", frm(6'd1, 32'd0, 8'h01), 8'h01);
    cmd_r1("cmd1_c", frm(6'd1, 32'd0, 8'h01), 8'h00);
    chk("ready_at_r1", card_ready, 0);
    @(negedge clk);
    chk("ready_after", card_ready, 1);
    rd_base  = 32'h200;
    rd_mark  = rd_cnt;
    base_cnt = rd_cnt;
    rd_chk   = 1'b1;
    cmd_r1("cmd17", frm(6'd17, 32'h200, 8'h01), 8'h00);
    full_block(32'h200);
    rd_chk = 1'b0;
    chk("rd_count", rd_cnt - base_cnt, 512);
    chk("adr_hold", mem_adr, 32'h3FF);
    cmd_r1("cmd17_mis", frm(6'd17, 32'h201, 8'h01), 8'h20);
    zeros(30, z);
    chk("mis_notoken", z, 0);
    cmd_r1("cmd9", frm(6'd9, 32'd0, 8'h01), 8'h04);
    chk("cmd9_last", last_cmd, 9);
    send({2'b00, 6'd13, 32'd0, 8'h01});
    zeros(40, z);
    chk("badtx_do", z, 0);
    chk("badtx_last", last_cmd, 9);
    cmd_r1("cmd17_cs", frm(6'd17, 32'd0, 8'h01), 8'h00);
    rd(16, v);
    rd(8, v);
    chk("cs_token", v, 32'hFE);
    for (int k = 0; k < 10; k++) rd(8, v);
    rd(2, v);
    chk("cs_byte10_hi", v, 32'h0);
    cs = 1'b1;
    @(negedge clk);
    chk("cs_do", do_w, 1);
    chk("cs_rd", mem_rd, 0);
    repeat (3) @(negedge clk);
    cs = 1'b0;
    chk("cs_ready", card_ready, 1);
    rd_base  = 32'd0;
    rd_mark  = rd_cnt;
    base_cnt = rd_cnt;
    rd_chk   = 1'b1;
    cmd_r1("cmd17_after_cs", frm(6'd17, 32'd0, 8'h01), 8'h00);
    full_block(32'd0);
    rd_chk = 1'b0;
    chk("rd_count2", rd_cnt - base_cnt, 512);
    chk("ready_kept", card_ready, 1);
    send(frm(6'd17, 32'd0, 8'h01));
    rd(40, v);
    rst_x = 1'b0;
    @(negedge clk);
    chk("midrst_do", do_w, 1);
    chk("midrst_rd", mem_rd, 0);
    chk("midrst_adr", mem_adr, 0);
    chk("midrst_ready", card_ready, 0);
    chk("midrst_last", last_cmd, 0);
    rst_x = 1'b1;
    send(frm(6'd17, 32'd0, 8'h01));
    zeros(60, z);
    chk("midrst_uninit", z, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
